// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter that funnels per-lane LSU loads and stores onto a single
// memory read channel and a single memory write channel, one transaction at a time.
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IDX_W = $clog2(NUM_CONSUMERS);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_CONSUMERS - 1);
  localparam logic [IDX_W:0]   LANES     = (IDX_W+1)'(NUM_CONSUMERS);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    READ_WAITING  = 2'd1,
    WRITE_WAITING = 2'd2,
    RELAYING      = 2'd3
  } state_t;

  state_t                             state, state_next;
  logic [IDX_W-1:0]                   rr_ptr, rr_ptr_next;
  logic [IDX_W-1:0]                   grant, grant_next;
  logic                               serve_read, serve_read_next;
  logic                               mem_read_valid_next;
  logic [ADDR_BITS-1:0]               mem_read_address_next;
  logic                               mem_write_valid_next;
  logic [ADDR_BITS-1:0]               mem_write_address_next;
  logic [DATA_BITS-1:0]               mem_write_data_next;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_next;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready_next;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_next;

  logic                               req_found;
  logic [IDX_W-1:0]                   req_lane;
  logic [IDX_W:0]                     scan_sum;
  logic [IDX_W-1:0]                   scan_lane;
  logic                               req_is_read;
  logic [ADDR_BITS-1:0]               sel_read_addr;
  logic [ADDR_BITS-1:0]               sel_write_addr;
  logic [DATA_BITS-1:0]               sel_write_data;
  logic                               held_valid;

  // First requesting lane at or after rr_ptr, wrapping at NUM_CONSUMERS.
  always_comb begin
    req_found = 1'b0;
    req_lane  = rr_ptr;
    scan_sum  = '0;
    scan_lane = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan_sum >= LANES) begin
        scan_sum = scan_sum - LANES;
      end
      scan_lane = scan_sum[IDX_W-1:0];
      if (!req_found && (consumer_read_valid[scan_lane] || consumer_write_valid[scan_lane])) begin
        req_found = 1'b1;
        req_lane  = scan_lane;
      end
    end
  end

  always_comb begin
    req_is_read    = 1'b0;
    sel_read_addr  = '0;
    sel_write_addr = '0;
    sel_write_data = '0;
    held_valid     = 1'b0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (req_lane == IDX_W'(i)) begin
        req_is_read    = consumer_read_valid[i];
        sel_read_addr  = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        sel_write_addr = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        sel_write_data = consumer_write_data[i*DATA_BITS +: DATA_BITS];
      end
      if (grant == IDX_W'(i)) begin
        held_valid = serve_read ? consumer_read_valid[i] : consumer_write_valid[i];
      end
    end
  end

  always_comb begin
    state_next                = state;
    rr_ptr_next               = rr_ptr;
    grant_next                = grant;
    serve_read_next           = serve_read;
    mem_read_valid_next       = mem_read_valid;
    mem_read_address_next     = mem_read_address;
    mem_write_valid_next      = mem_write_valid;
    mem_write_address_next    = mem_write_address;
    mem_write_data_next       = mem_write_data;
    consumer_read_ready_next  = consumer_read_ready;
    consumer_write_ready_next = consumer_write_ready;
    consumer_read_data_next   = consumer_read_data;

    unique case (state)
      IDLE: begin
        if (req_found) begin
          grant_next      = req_lane;
          serve_read_next = req_is_read;
          // A lane asking for both is served as a read; its write waits for a later grant.
          if (req_is_read) begin
            mem_read_valid_next   = 1'b1;
            mem_read_address_next = sel_read_addr;
            state_next            = READ_WAITING;
          end else begin
            mem_write_valid_next   = 1'b1;
            mem_write_address_next = sel_write_addr;
            mem_write_data_next    = sel_write_data;
            state_next             = WRITE_WAITING;
          end
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          mem_read_valid_next = 1'b0;
          state_next          = RELAYING;
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (grant == IDX_W'(i)) begin
              consumer_read_ready_next[i]                    = 1'b1;
              consumer_read_data_next[i*DATA_BITS +: DATA_BITS] = mem_read_data;
            end
          end
        end
      end
      WRITE_WAITING: begin
        if (mem_write_ready) begin
          mem_write_valid_next = 1'b0;
          state_next           = RELAYING;
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (grant == IDX_W'(i)) begin
              consumer_write_ready_next[i] = 1'b1;
            end
          end
        end
      end
      RELAYING: begin
        if (!held_valid) begin
          consumer_read_ready_next  = '0;
          consumer_write_ready_next = '0;
          state_next                = IDLE;
          rr_ptr_next               = (grant == LAST_LANE) ? '0 : grant + IDX_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant                <= '0;
      serve_read           <= 1'b0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      state                <= state_next;
      rr_ptr               <= rr_ptr_next;
      grant                <= grant_next;
      serve_read           <= serve_read_next;
      mem_read_valid       <= mem_read_valid_next;
      mem_read_address     <= mem_read_address_next;
      mem_write_valid      <= mem_write_valid_next;
      mem_write_address    <= mem_write_address_next;
      mem_write_data       <= mem_write_data_next;
      consumer_read_ready  <= consumer_read_ready_next;
      consumer_write_ready <= consumer_write_ready_next;
      consumer_read_data   <= consumer_read_data_next;
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Self-checking bench for lsu_mem_arbiter: directed scenarios plus randomized
// lane/memory traffic compared every cycle against a transaction-level model.
module tb_lsu_mem_arbiter;

  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   rv, wv;
  logic [N*A-1:0] ra, wa;
  logic [N*D-1:0] wd;
  logic           mem_read_ready, mem_write_ready;
  logic [D-1:0]   mem_read_data;

  logic [N-1:0]   crr, cwr;
  logic [N*D-1:0] crd;
  logic           mrv, mwv;
  logic [A-1:0]   mra, mwa;
  logic [D-1:0]   mwd;

  int vectors     = 0;
  int miscompares = 0;

  lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .consumer_read_valid    (rv),
    .consumer_read_address  (ra),
    .consumer_read_ready    (crr),
    .consumer_read_data     (crd),
    .consumer_write_valid   (wv),
    .consumer_write_address (wa),
    .consumer_write_data    (wd),
    .consumer_write_ready   (cwr),
    .mem_read_valid         (mrv),
    .mem_read_address       (mra),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mwv),
    .mem_write_address      (mwa),
    .mem_write_data         (mwd),
    .mem_write_ready        (mem_write_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Transaction-level model: one outstanding transaction (phase 0 none,
  // 1 at memory, 2 handing back), next winner = nearest requester after m_rr.
  int             m_phase, m_rr, m_lane, m_pick, m_pick_d;
  logic           m_read, m_held;
  logic           e_mrv, e_mwv;
  logic [A-1:0]   e_mra, e_mwa;
  logic [D-1:0]   e_mwd;
  logic [N-1:0]   e_crr, e_cwr;
  logic [N*D-1:0] e_crd;

  always_comb begin
    m_pick   = -1;
    m_pick_d = N;
    m_held   = 1'b0;
    for (int l = 0; l < N; l++) begin
      if ((rv[l] || wv[l]) && (((l - m_rr + N) % N) < m_pick_d)) begin
        m_pick_d = (l - m_rr + N) % N;
        m_pick   = l;
      end
      if (l == m_lane) m_held = m_read ? rv[l] : wv[l];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_rr <= 0; m_lane <= 0; m_read <= 1'b0;
      e_mrv <= 1'b0; e_mwv <= 1'b0; e_mra <= '0; e_mwa <= '0; e_mwd <= '0;
      e_crr <= '0; e_cwr <= '0; e_crd <= '0;
    end else begin
      case (m_phase)
        0: for (int l = 0; l < N; l++) begin
          if (l == m_pick) begin
            m_lane  <= l;
            m_read  <= rv[l];
            m_phase <= 1;
            if (rv[l]) begin
              e_mrv <= 1'b1; e_mra <= ra[l*A +: A];
            end else begin
              e_mwv <= 1'b1; e_mwa <= wa[l*A +: A]; e_mwd <= wd[l*D +: D];
            end
          end
        end
        1: if (m_read && mem_read_ready) begin
          e_mrv <= 1'b0; m_phase <= 2;
          for (int l = 0; l < N; l++) if (l == m_lane) begin
            e_crr[l] <= 1'b1; e_crd[l*D +: D] <= mem_read_data;
          end
        end else if (!m_read && mem_write_ready) begin
          e_mwv <= 1'b0; m_phase <= 2;
          for (int l = 0; l < N; l++) if (l == m_lane) e_cwr[l] <= 1'b1;
        end
        default: if (!m_held) begin
          e_crr <= '0; e_cwr <= '0; m_rr <= (m_lane + 1) % N; m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("mem_read_valid",   32'(mrv), 32'(e_mrv));
    check("mem_read_address", 32'(mra), 32'(e_mra));
    check("mem_write_valid",  32'(mwv), 32'(e_mwv));
    check("mem_write_addr",   32'(mwa), 32'(e_mwa));
    check("mem_write_data",   32'(mwd), 32'(e_mwd));
    check("cons_read_ready",  32'(crr), 32'(e_crr));
    check("cons_write_ready", 32'(cwr), 32'(e_cwr));
    check("cons_read_data",   32'(crd), 32'(e_crd));
    check("one_mem_valid",    32'($countones({mrv, mwv}) <= 1), 32'd1);
    check("one_cons_ready",   32'($countones({crr, cwr}) <= 1), 32'd1);
  end

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (crr[i]) rv[i] = 1'b0;
      if (cwr[i]) wv[i] = 1'b0;
    end
  endtask

  task automatic wait_grant();
    for (int c = 0; c < 30; c++) begin
      step();
      if (mrv || mwv) break;
    end
    check("grant_seen", 32'(mrv | mwv), 32'd1);
  endtask

  task automatic reset_dut();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rv = '0; wv = '0;
    ra = 32'h23222120; wa = 32'h33323130; wd = 32'hB3B2B1B0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
    repeat (3) @(negedge clk);
    check("rst_mrv",   32'(mrv), 32'd0);
    check("rst_mwv",   32'(mwv), 32'd0);
    check("rst_crr",   32'(crr), 32'd0);
    check("rst_cwr",   32'(cwr), 32'd0);
    check("rst_crd",   32'(crd), 32'd0);
    check("rst_mwa",   32'(mwa), 32'd0);
    check("rst_model", 32'({e_mrv, e_mwv, e_crr, e_cwr}), 32'd0);
    rst_n = 1'b1;

    // Lane 2 read 0x1A, memory answers 0x5C one cycle later.
    ra[2*A +: A] = 8'h1A; rv[2] = 1'b1;
    @(negedge clk);
    check("l2_mrv",       32'(mrv), 32'd1);
    check("l2_mra",       32'(mra), 32'h1A);
    check("l2_model_mra", 32'(e_mra), 32'h1A);
    mem_read_ready = 1'b1; mem_read_data = 8'h5C;
    @(negedge clk);
    check("l2_ready",     32'(crr), 32'h4);
    check("l2_data",      32'(crd[2*D +: D]), 32'h5C);
    check("l2_model_crd", 32'(e_crd[2*D +: D]), 32'h5C);
    check("l2_mrv_low",   32'(mrv), 32'd0);
    mem_read_ready = 1'b0;
    @(negedge clk);
    check("l2_ready_hold", 32'(crr), 32'h4);
    rv[2] = 1'b0;
    @(negedge clk);
    check("l2_ready_fall", 32'(crr), 32'h0);
    check("l2_data_keep",  32'(crd[2*D +: D]), 32'h5C);
    ra[2*A +: A] = 8'h22;

    // All four lanes write at once after reset: grants in lane order.
    reset_dut();
    mem_read_ready = 1'b1; mem_write_ready = 1'b1; wv = 4'hF;
    for (int i = 0; i < N; i++) begin
      wait_grant();
      check("wr_order_addr", 32'(mwa), 32'h30 + 32'(i));
      check("wr_order_data", 32'(mwd), 32'hB0 + 32'(i));
    end
    repeat (4) step();

    // Lane 3 was served last, so lane 0 beats lane 3.
    rv = 4'b1001;
    wait_grant();
    check("wrap_first",  32'(mra), 32'h20);
    wait_grant();
    check("wrap_second", 32'(mra), 32'h23);
    repeat (4) step();

    // Lane 1 with read and write: read first, write on a later grant.
    rv[1] = 1'b1; wv[1] = 1'b1;
    wait_grant();
    check("both_rd_valid", 32'(mrv), 32'd1);
    check("both_rd_addr",  32'(mra), 32'h21);
    wait_grant();
    check("both_wr_valid", 32'(mwv), 32'd1);
    check("both_wr_addr",  32'(mwa), 32'h31);
    check("both_wr_data",  32'(mwd), 32'hB1);
    repeat (4) step();

    // Memory stalls 10 cycles while lane 0 abandons its request.
    mem_read_ready = 1'b0; rv[0] = 1'b1;
    step();
    check("stall_mrv", 32'(mrv), 32'd1);
    rv[0] = 1'b0; ra[A-1:0] = 8'h99;
    for (int c = 0; c < 10; c++) begin
      step();
      check("stall_hold_v", 32'(mrv), 32'd1);
      check("stall_hold_a", 32'(mra), 32'h20);
    end
    mem_read_ready = 1'b1; mem_read_data = 8'h77;
    step();
    check("stall_ready", 32'(crr), 32'h1);
    check("stall_data",  32'(crd[D-1:0]), 32'h77);
    mem_read_ready = 1'b0;
    step();
    check("stall_ready_fall", 32'(crr), 32'h0);
    ra[A-1:0] = 8'h20;

    // Reset while lane 2's read is outstanding.
    rv[2] = 1'b1;
    step();
    check("rstmid_mrv", 32'(mrv), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_async_mrv", 32'(mrv), 32'd0);
    check("rstmid_async_crr", 32'(crr), 32'd0);
    rv[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_read_ready = 1'b1; rv[1] = 1'b1;
    wait_grant();
    check("rstmid_regrant", 32'(mra), 32'h21);
    repeat (4) step();

    // Randomized lanes and memory, with one asynchronous reset mid-run.
    for (int it = 0; it < 2500; it++) begin
      @(negedge clk);
      if (it == 1200) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (rv[i]) begin
          if (crr[i]) begin
            if ($urandom_range(2) != 0) rv[i] = 1'b0;
          end else if ($urandom_range(39) == 0) rv[i] = 1'b0;
          else if ($urandom_range(7) == 0) ra[i*A +: A] = A'($urandom);
        end else if (!crr[i] && $urandom_range(5) == 0) begin
          rv[i] = 1'b1; ra[i*A +: A] = A'($urandom);
        end
        if (wv[i]) begin
          if (cwr[i]) begin
            if ($urandom_range(2) != 0) wv[i] = 1'b0;
          end else if ($urandom_range(39) == 0) wv[i] = 1'b0;
          else if ($urandom_range(7) == 0) wd[i*D +: D] = D'($urandom);
        end else if (!cwr[i] && $urandom_range(5) == 0) begin
          wv[i] = 1'b1; wa[i*A +: A] = A'($urandom); wd[i*D +: D] = D'($urandom);
        end
      end
      mem_read_ready  = ($urandom_range(1) == 1);
      mem_write_ready = ($urandom_range(1) == 1);
      mem_read_data   = D'($urandom);
    end
    rv = '0; wv = '0; mem_read_ready = 1'b1; mem_write_ready = 1'b1;
    repeat (6) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
